tausworthe_ctrl: RTL and testbench
==================================

Name: tausworthe_ctrl

Overview:
- Sequencer for the three-component Tausworthe URNG (taus88) at the front of the AWGN chain.
- Accepts three 32-bit seeds over a register-write port and sanitises them against the taus88 minimums.
- Runs a configurable warm-up of discarded steps, then streams uniform words downstream over a valid/ready handshake.
- Holds generator state under backpressure so no sample is lost or repeated.

Parameters:
- WIDTH, 32, URNG word width; fixed at 32, since the taus88 shift constants assume it.
- WARMUP, 8, number of discarded steps after seeding (0 allowed).
- DEF_S0, 32'h0000_1234, replacement seed for component 0.
- DEF_S1, 32'h0000_5678, replacement seed for component 1.
- DEF_S2, 32'h0009_ABCD, replacement seed for component 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- seed_wr  in  1  seed write strobe.
- seed_sel  in  2  seed index 0..2; 3 is ignored.
- seed_data  in  32  seed value.
- start  in  1  pulse: load staged seeds and begin warm-up.
- stop  in  1  pulse: return to IDLE.
- out_data  out  32  uniform sample, s0^s1^s2.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the sample.
- busy  out  1  high in LOAD, WARM or RUN.

Behaviour:
- Reset: all outputs 0. State IDLE. Staged seeds = DEF_*. Generator state s0/s1/s2 = 0. Warm counter = 0.
- Seed staging:
  - seed_wr writes seed_data into staged[seed_sel] in any state.
  - A write does not affect the running generator until the next start.
- Seed sanitising is applied at LOAD. A staged seed below its minimum is replaced by DEF_*:
  - s0 < 2 → DEF_S0.
  - s1 < 8 → DEF_S1.
  - s2 < 16 → DEF_S2.
- Step function (combinational, mod 2^32):
  - s0' = ((s0 & FFFFFFFE) << 12) ^ (((s0 << 13) ^ s0) >> 19)
  - s1' = ((s1 & FFFFFFF8) << 4) ^ (((s1 << 2) ^ s1) >> 25)
  - s2' = ((s2 & FFFFFFF0) << 17) ^ (((s2 << 3) ^ s2) >> 11)
- FSM states: IDLE, LOAD, WARM, RUN.
  - IDLE: out_valid = 0, busy = 0. start → LOAD.
  - LOAD (1 cycle): s* ← sanitised staged seeds. Warm counter ← WARMUP. Next state is WARM, or RUN if WARMUP = 0.
  - WARM: s* ← step(s*) every cycle and the counter decrements. When the counter reaches 1 (i.e. after WARMUP steps), go to RUN. out_valid = 0 throughout.
  - RUN:
    - out_data/out_valid are registered.
    - On RUN entry, take one step: out_data ← s0'^s1'^s2' and out_valid ← 1. The first sample appears 1 cycle after RUN entry.
    - While out_valid && !out_ready: out_data and s* hold.
    - On out_valid && out_ready: step again and present the next sample the following cycle, giving 1 sample per clock under full throughput.
- Latency: with WARMUP = N, the first out_valid appears N+2 cycles after the start pulse (LOAD, N warm steps, first step).
- stop (any non-IDLE state) → IDLE next cycle. out_valid drops in that cycle even if a sample is unaccepted; the sample is discarded.
- start while busy restarts: → LOAD and reloads seeds. out_valid drops.
- start and stop in the same cycle: stop wins.
- Asynchronous rst mid-operation: immediate return to reset values. Staged seeds revert to DEF_*.
- seed_wr with seed_sel = 3: no effect.

Decomposition:
- Shared package awgn_pkg holds:
  - WIDTH.
  - The taus88 shift constants (13/19/12, 2/25/4, 3/11/17) and masks (FFFFFFFE/FFFFFFF8/FFFFFFF0).
  - Seed minimums 2/8/16.
  - The FSM state enumeration.
- One sub-module is natural: taus_step. It is a purely combinational s0/s1/s2 → s0'/s1'/s2' plus out. It is reusable by the existing Tausworthe datapath and by the bench model.

Test Plan:
- Reset, then stage seeds 2/8/16, WARMUP = 0, start, out_ready = 1. Expect:
  - First out_data = 32'h0020_2080 at cycle start+2.
  - Next out_data = 32'h0200_2C80.
  - busy = 1.
- Stage seed 0 = 0, seed 1 = 3, seed 2 = 5, then start. Expect the generator to load 1234/5678/9ABCD (hex), with output equal to the golden taus88 model on those seeds.
- WARMUP = 4 on seeds 2/8/16. Expect out_valid first high 6 cycles after start, with out_data equal to the 5th golden step.
- Backpressure: hold out_ready = 0 for 5 cycles mid-stream. Expect out_data stable and out_valid high. On release, expect the sequence to continue with no skipped or duplicated word versus golden.
- stop during RUN with an unaccepted sample. Expect out_valid = 0 and busy = 0 next cycle. A following start reproduces the sequence from the first sample.
- Assert rst in WARM. Expect all outputs 0 immediately and staged seeds = defaults. start after reset yields the DEF_* sequence.

Source files
------------

// File: rtl/awgn_pkg.sv
// Shared constants, state type and seed helper for the AWGN chain's taus88 URNG.
// Holds the taus88 shifts and masks, the seed minimums and the sequencer state enum.
package awgn_pkg;

    localparam int WIDTH = 32;

    // taus88 component shifts: (left, right, final left)
    localparam int T0_A = 13;
    localparam int T0_B = 19;
    localparam int T0_C = 12;
    localparam int T1_A = 2;
    localparam int T1_B = 25;
    localparam int T1_C = 4;
    localparam int T2_A = 3;
    localparam int T2_B = 11;
    localparam int T2_C = 17;

    localparam logic [WIDTH-1:0] MASK0 = 32'hFFFF_FFFE;
    localparam logic [WIDTH-1:0] MASK1 = 32'hFFFF_FFF8;
    localparam logic [WIDTH-1:0] MASK2 = 32'hFFFF_FFF0;

    localparam logic [WIDTH-1:0] MIN0 = 32'd2;
    localparam logic [WIDTH-1:0] MIN1 = 32'd8;
    localparam logic [WIDTH-1:0] MIN2 = 32'd16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WARM,
        ST_RUN
    } state_t;

    // A seed below its component minimum degenerates the generator.
    function automatic logic [WIDTH-1:0] sanitise(
        input logic [WIDTH-1:0] seed,
        input logic [WIDTH-1:0] min,
        input logic [WIDTH-1:0] def
    );
        return (seed < min) ? def : seed;
    endfunction

endpackage

// File: rtl/taus_step.sv
// One combinational taus88 step: s0/s1/s2 -> next state and output word.
// Ports: s0..s2 current state; n0..n2 next state; out = n0^n1^n2.
module taus_step
    import awgn_pkg::*;
(
    input  logic [WIDTH-1:0] s0,
    input  logic [WIDTH-1:0] s1,
    input  logic [WIDTH-1:0] s2,
    output logic [WIDTH-1:0] n0,
    output logic [WIDTH-1:0] n1,
    output logic [WIDTH-1:0] n2,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        n0  = ((s0 & MASK0) << T0_C) ^ (((s0 << T0_A) ^ s0) >> T0_B);
        n1  = ((s1 & MASK1) << T1_C) ^ (((s1 << T1_A) ^ s1) >> T1_B);
        n2  = ((s2 & MASK2) << T2_C) ^ (((s2 << T2_A) ^ s2) >> T2_B);
        out = n0 ^ n1 ^ n2;
    end

endmodule

// File: rtl/tausworthe_ctrl.sv
// taus88 sequencer: seed staging, sanitised load, warm-up, valid/ready stream.
// Ports: seed_wr/seed_sel/seed_data stage seeds; start/stop control;
//        out_data/out_valid/out_ready stream; busy when not IDLE.
module tausworthe_ctrl
    import awgn_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter int               WARMUP = 8,
    parameter logic [WIDTH-1:0] DEF_S0 = 32'h0000_1234,
    parameter logic [WIDTH-1:0] DEF_S1 = 32'h0000_5678,
    parameter logic [WIDTH-1:0] DEF_S2 = 32'h0009_ABCD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_wr,
    input  logic [1:0]       seed_sel,
    input  logic [WIDTH-1:0] seed_data,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

    state_t state, next_state;

    logic [WIDTH-1:0] stg0, stg1, stg2;
    logic [WIDTH-1:0] s0, s1, s2;
    logic [WIDTH-1:0] n0, n1, n2, nout;
    logic [CW-1:0]    cnt;
    logic             abort;

    taus_step u_step (
        .s0  (s0),
        .s1  (s1),
        .s2  (s2),
        .n0  (n0),
        .n1  (n1),
        .n2  (n2),
        .out (nout)
    );

    // Any start or stop leaves the current state; stop wins in next_state.
    assign abort = start | stop;
    assign busy  = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: next_state = ST_IDLE;
            ST_LOAD: next_state = (WARMUP == 0) ? ST_RUN : ST_WARM;
            ST_WARM: if (cnt == CW'(1)) next_state = ST_RUN;
            ST_RUN:  next_state = ST_RUN;
        endcase
        if (stop)       next_state = ST_IDLE;
        else if (start) next_state = ST_LOAD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg0      <= DEF_S0;
            stg1      <= DEF_S1;
            stg2      <= DEF_S2;
            s0        <= '0;
            s1        <= '0;
            s2        <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (seed_wr) begin
                case (seed_sel)
                    2'd0:    stg0 <= seed_data;
                    2'd1:    stg1 <= seed_data;
                    2'd2:    stg2 <= seed_data;
                    default: ;
                endcase
            end

            unique case (state)
                ST_IDLE: ;
                ST_LOAD: begin
                    s0  <= sanitise(stg0, MIN0, DEF_S0);
                    s1  <= sanitise(stg1, MIN1, DEF_S1);
                    s2  <= sanitise(stg2, MIN2, DEF_S2);
                    cnt <= CW'(WARMUP);
                end
                ST_WARM: begin
                    s0  <= n0;
                    s1  <= n1;
                    s2  <= n2;
                    cnt <= cnt - CW'(1);
                end
                ST_RUN: begin
                    // Step only when the slot is empty or being taken,
                    // so a stalled sample is neither lost nor repeated.
                    if (!abort && (!out_valid || out_ready)) begin
                        s0        <= n0;
                        s1        <= n1;
                        s2        <= n2;
                        out_data  <= nout;
                        out_valid <= 1'b1;
                    end
                end
            endcase

            if (abort) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tausworthe_ctrl.sv
// Self-checking bench for tausworthe_ctrl (WARMUP=0 and WARMUP=4 instances).
// Table vectors for first samples plus scoreboard-driven stream sequences.
module tb_tausworthe_ctrl;

    localparam logic [31:0] D0 = 32'h0000_1234;
    localparam logic [31:0] D1 = 32'h0000_5678;
    localparam logic [31:0] D2 = 32'h0009_ABCD;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_wr;
    logic [1:0]  seed_sel;
    logic [31:0] seed_data;
    logic        start;
    logic        stop;
    logic        out_ready;
    logic [31:0] d0, d4;
    logic        v0, v4, b0, b4;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    tausworthe_ctrl #(.WARMUP(0)) dut0 (
        .clk(clk), .rst(rst), .seed_wr(seed_wr), .seed_sel(seed_sel),
        .seed_data(seed_data), .start(start), .stop(stop),
        .out_data(d0), .out_valid(v0), .out_ready(out_ready), .busy(b0)
    );

    tausworthe_ctrl #(.WARMUP(4)) dut4 (
        .clk(clk), .rst(rst), .seed_wr(seed_wr), .seed_sel(seed_sel),
        .seed_data(seed_data), .start(start), .stop(stop),
        .out_data(d4), .out_valid(v4), .out_ready(out_ready), .busy(b4)
    );

    function automatic logic [31:0] st0(input logic [31:0] s);
        return ((s & 32'hFFFFFFFE) << 12) ^ (((s << 13) ^ s) >> 19);
    endfunction
    function automatic logic [31:0] st1(input logic [31:0] s);
        return ((s & 32'hFFFFFFF8) << 4) ^ (((s << 2) ^ s) >> 25);
    endfunction
    function automatic logic [31:0] st2(input logic [31:0] s);
        return ((s & 32'hFFFFFFF0) << 17) ^ (((s << 3) ^ s) >> 11);
    endfunction

    // k-th output word (k >= 1) from already-sanitised seeds
    function automatic logic [31:0] nth(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input int k);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < k; i++) begin
            a = st0(a);
            b = st1(b);
            c = st2(c);
            o = a ^ b ^ c;
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wr_seed(input logic [1:0] sel, input logic [31:0] data);
        seed_wr = 1'b1;
        seed_sel = sel;
        seed_data = data;
        @(negedge clk);
        seed_wr = 1'b0;
    endtask

    task automatic stage(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        wr_seed(2'd0, a);
        wr_seed(2'd1, b);
        wr_seed(2'd2, c);
    endtask

    task automatic pulse(input logic do_start, input logic do_stop);
        start = do_start;
        stop = do_stop;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
    endtask

    // Edges counted from the edge that sampled start; bounded.
    task automatic wait_valid(input logic which, output int c);
        c = 0;
        while (!(which ? v4 : v0) && c < 50) begin
            @(negedge clk);
            c++;
        end
    endtask

    typedef struct {
        logic [31:0] s0, s1, s2;
        logic [31:0] e0, e1;
        string       name;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int c;
        int cyc;
        logic [31:0] e;

        tbl[0] = '{32'd2, 32'd8, 32'd16, 32'h0020_2080, 32'h0200_2C80, "min"};
        tbl[1] = '{32'd0, 32'd3, 32'd5, nth(D0, D1, D2, 1), nth(D0, D1, D2, 2), "low"};
        tbl[2] = '{32'd1, 32'd7, 32'd15, nth(D0, D1, D2, 1), nth(D0, D1, D2, 2), "edge"};
        tbl[3] = '{32'h8765_4321, 32'hCAFE_F00D, 32'h1357_9BDF,
                   nth(32'h8765_4321, 32'hCAFE_F00D, 32'h1357_9BDF, 1),
                   nth(32'h8765_4321, 32'hCAFE_F00D, 32'h1357_9BDF, 2), "big"};

        rst = 1'b1;
        seed_wr = 1'b0;
        seed_sel = 2'd0;
        seed_data = '0;
        start = 1'b0;
        stop = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_data", d0, 32'h0);
        chk("rst_valid", {31'b0, v0}, 32'h0);
        chk("rst_busy", {31'b0, b0}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // first two samples for each seed vector, WARMUP=0
        for (int i = 0; i < 4; i++) begin
            stage(tbl[i].s0, tbl[i].s1, tbl[i].s2);
            pulse(1'b1, 1'b0);
            wait_valid(1'b0, c);
            chk({tbl[i].name, "_lat"}, c, 2);
            chk({tbl[i].name, "_first"}, d0, tbl[i].e0);
            @(negedge clk);
            chk({tbl[i].name, "_second"}, d0, tbl[i].e1);
            chk({tbl[i].name, "_busy"}, {31'b0, b0}, 32'h1);
            pulse(1'b0, 1'b1);
        end

        // WARMUP=4 latency and value
        stage(32'd2, 32'd8, 32'd16);
        pulse(1'b1, 1'b0);
        wait_valid(1'b1, c);
        chk("warm4_lat", c, 6);
        chk("warm4_data", d4, nth(32'd2, 32'd8, 32'd16, 5));
        pulse(1'b0, 1'b1);

        // scoreboard stream with a 5-cycle stall and mid-stream seed writes
        exp_q.delete();
        pulse(1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) exp_q.push_back(nth(32'd2, 32'd8, 32'd16, k));
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            seed_wr = (cyc == 2 || cyc == 3);
            seed_sel = (cyc == 2) ? 2'd0 : 2'd3;
            seed_data = (cyc == 2) ? 32'hDEAD_BEEF : 32'h0;
            if (v0 && out_ready) begin
                chk("sb_word", d0, exp_q.pop_front());
            end else if (v0) begin
                chk("stall_data", d0, exp_q[0]);
            end
            @(negedge clk);
            cyc++;
        end
        seed_wr = 1'b0;
        out_ready = 1'b1;
        chk("sb_left", exp_q.size(), 0);

        // stop with an unaccepted sample; staged seed0 now DEADBEEF, sel 3 ignored
        pulse(1'b0, 1'b1);
        out_ready = 1'b0;
        e = nth(32'hDEAD_BEEF, 32'd8, 32'd16, 1);
        pulse(1'b1, 1'b0);
        wait_valid(1'b0, c);
        chk("stop_pre", d0, e);
        @(negedge clk);
        pulse(1'b0, 1'b1);
        chk("stop_valid", {31'b0, v0}, 32'h0);
        chk("stop_busy", {31'b0, b0}, 32'h0);
        out_ready = 1'b1;
        pulse(1'b1, 1'b0);
        wait_valid(1'b0, c);
        chk("restart_first", d0, e);

        // start while running restarts the sequence
        @(negedge clk);
        pulse(1'b1, 1'b0);
        chk("rs_valid", {31'b0, v0}, 32'h0);
        chk("rs_busy", {31'b0, b0}, 32'h1);
        wait_valid(1'b0, c);
        chk("rs_lat", c, 2);
        chk("rs_first", d0, e);

        // start and stop together: stop wins
        pulse(1'b1, 1'b1);
        chk("both_busy", {31'b0, b0}, 32'h0);
        chk("both_valid", {31'b0, v0}, 32'h0);

        // async reset while dut4 is in WARM
        pulse(1'b1, 1'b0);
        @(negedge clk);
        chk("warm_busy", {31'b0, b4}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_d0", d0, 32'h0);
        chk("arst_v0", {31'b0, v0}, 32'h0);
        chk("arst_b4", {31'b0, b4}, 32'h0);
        chk("arst_d4", d4, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse(1'b1, 1'b0);
        wait_valid(1'b0, c);
        chk("def_first", d0, nth(D0, D1, D2, 1));
        @(negedge clk);
        chk("def_second", d0, nth(D0, D1, D2, 2));
        wait_valid(1'b1, c);
        chk("def_warm4", d4, nth(D0, D1, D2, 5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
